// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with configurable word width, runtime CPOL/CPHA, multiple chip selects
// and a clk-domain SCLK divider; sclk is a registered output, no derived clocks.
module spi_master_cfg #(
   parameter int DATA_W   = 32,
   parameter int CLK_DIV  = 25,
   parameter int NUM_CS   = 1,
   parameter int CS_SEL_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATA_W-1:0]   tx_data,
   input  logic [1:0]          mode,
   input  logic [CS_SEL_W-1:0] cs_sel,
   output logic [DATA_W-1:0]   rx_data,
   output logic                busy,
   output logic                done,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso,
   output logic [NUM_CS-1:0]   cs_n
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int HP_W  = $clog2(2 * DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [HP_W-1:0]   hp_q, hp_d;
   logic [DATA_W-1:0] sh_q, sh_d, rx_q, rx_d;
   logic [1:0]        mode_q, mode_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d, cs_dec;
   logic              busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic              accept, tick, leading, sample, drive;

   // out-of-range cs_sel decodes to no select at all
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (cs_sel == CS_SEL_W'(i)) cs_dec[i] = 1'b0;
   end

   assign accept  = start && !busy_q;
   assign tick    = state_q != IDLE && div_q == DIV_LAST;
   assign leading = !hp_q[0];
   // one shift register both serialises tx and collects rx
   assign sample  = state_q == XFER && tick && (leading ^ mode_q[0]);
   assign drive   = state_q == XFER && tick && (mode_q[0] ? leading : !leading && hp_q != HP_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = state_q == IDLE || tick ? '0 : div_q + DIV_W'(1);
      hp_d    = hp_q;
      sh_d    = sample ? {sh_q[DATA_W-2:0], miso} : sh_q;
      rx_d    = rx_q;
      mode_d  = mode_q;
      cs_n_d  = cs_n_q;
      busy_d  = done_q ? 1'b0 : busy_q;
      done_d  = 1'b0;
      sclk_d  = state_q == IDLE ? mode_q[1] : state_q == XFER && tick ? !sclk_q : sclk_q;
      mosi_d  = drive ? sh_q[DATA_W-1] : mosi_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = SETUP;
            hp_d    = '0;
            mode_d  = mode;
            sh_d    = tx_data;
            cs_n_d  = cs_dec;
            busy_d  = 1'b1;
            sclk_d  = mode[1];
            mosi_d  = mode[0] ? mosi_q : tx_data[DATA_W-1];
         end
         SETUP: if (tick) state_d = XFER;
         XFER: if (tick) begin
            state_d = hp_q == HP_LAST ? HOLD : XFER;
            hp_d    = hp_q == HP_LAST ? '0 : hp_q + HP_W'(1);
         end
         HOLD: if (tick) begin
            state_d = IDLE;
            cs_n_d  = '1;
            rx_d    = sh_q;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         hp_q    <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         mode_q  <= '0;
         cs_n_q  <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hp_q    <= hp_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         mode_q  <= mode_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end

   assign rx_data = rx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;
endmodule
